drbg_access_arbiter: RTL
========================

DRBG_ACCESS_ARBITER -- requirements
Module: drbg_access_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: max cycles in WAIT before abort; 1..1023.
REQ-002 SHALL have parameter SEED_BURST_MAX, default 2: consecutive seed grants allowed while req_line pends.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port drbg_ready, input, 1: DRBG initialised and idle.
REQ-006 SHALL have port drbg_done, input, 1: one-cycle pulse when the issued DRBG command completes.
REQ-007 SHALL have port block_reseed, input, 1: seed commands inhibited while high.
REQ-008 SHALL have port req_sync, input, 1: level seed request from the synchronisator.
REQ-009 SHALL have port req_frame, input, 1: level seed request from the frame-boundary reseed logic.
REQ-010 SHALL have port req_line, input, 1: level random-bits request from the line scrambler.
REQ-011 SHALL have port next_seed, output, 1: one-cycle seed command to DRBG.
REQ-012 SHALL have port next_bits, output, 1: one-cycle bits command to DRBG.
REQ-013 SHALL have port grant, output, 3: one-hot {line, frame, sync}; held from ISSUE through ACK.
REQ-014 SHALL have port ack, output, 3: one-hot one-cycle completion pulse, same bit order.
REQ-015 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-016 SHALL have port timeout_err, output, 1: sticky abort flag.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
REQ-018 IDLE: when drbg_ready=1 and a qualified request exists, SHALL register grant and enter ISSUE next cycle; otherwise stay.
REQ-019 Qualification: req_sync and req_frame qualified only when block_reseed=0; req_line always qualified.
REQ-020 Priority SHALL be sync > frame > line, except line wins when seed_burst count = SEED_BURST_MAX and req_line qualified.
REQ-021 seed_burst count SHALL increment on each seed grant while req_line=1, saturate at SEED_BURST_MAX, clear on a line grant or when req_line=0 in IDLE.
REQ-022 ISSUE: SHALL pulse next_seed (sync/frame grant) or next_bits (line grant) for exactly one cycle, then enter WAIT; never both.
REQ-023 WAIT: SHALL count cycles from 1; drbg_done=1 -> ACK; count = TIMEOUT without done -> set timeout_err, clear grant, enter IDLE, no ack.
REQ-024 drbg_done and timeout in the same cycle: done wins, no error.
REQ-025 ACK: SHALL pulse ack bit matching grant for one cycle, clear grant on exit, return to IDLE.
REQ-026 drbg_done in IDLE, ISSUE or ACK SHALL be ignored.
REQ-027 Request deassertion after grant SHALL NOT abort the command; ack still issued.
REQ-028 block_reseed rising after ISSUE of a seed command SHALL NOT affect its completion.
REQ-029 A request still high after its ack SHALL be re-arbitrated normally (minimum 2 cycles ack to next command pulse).
REQ-030 Command pulse SHALL follow request qualification by exactly 2 cycles when IDLE and drbg_ready=1.
REQ-031 timeout_err SHALL clear only on reset.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE; grant, ack, next_seed, next_bits, busy, timeout_err = 0; counters = 0.
REQ-033 Reset asserted mid-WAIT SHALL discard the command; no ack after release.
REQ-034 Outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-035 req_sync=req_frame=req_line=1 at once, drbg_ready=1, done 5 cycles after each command -> grant order sync, frame, line (SEED_BURST_MAX=2), each ack once.
REQ-036 block_reseed=1, req_sync=req_line=1 -> only next_bits pulses, grant=3'b100; drop block_reseed -> next command is next_seed, grant=3'b001.
REQ-037 Single req_line, drbg_done never asserted, TIMEOUT=1023 -> no ack, timeout_err=1 exactly 1023 cycles after WAIT entry, busy=0 next cycle.
REQ-038 drbg_done and count=TIMEOUT coincide -> ack=3'b100, timeout_err stays 0.
REQ-039 reset_n pulsed low during WAIT -> all outputs 0 immediately; stray drbg_done after release produces no ack.
REQ-040 drbg_ready=0 with requests pending -> no command pulse; drbg_ready rising -> command pulse 2 cycles later.

Source files
------------

// File: rtl/drbg_access_arbiter.sv
// Arbitrates seed requests (sync, frame) and random-bits requests (line) onto a single DRBG
// command port; one command in flight at a time, bounded by a completion timeout.
module drbg_access_arbiter #(
   parameter int TIMEOUT        = 1023,
   parameter int SEED_BURST_MAX = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       drbg_ready,
   input  logic       drbg_done,
   input  logic       block_reseed,
   input  logic       req_sync,
   input  logic       req_frame,
   input  logic       req_line,
   output logic       next_seed,
   output logic       next_bits,
   output logic [2:0] grant,
   output logic [2:0] ack,
   output logic       busy,
   output logic       timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(SEED_BURST_MAX + 2);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [2:0]      grant_q, grant_d;
   logic [2:0]      ack_q, ack_d;
   logic            next_seed_q, next_seed_d;
   logic            next_bits_q, next_bits_d;
   logic            busy_q, busy_d;
   logic            timeout_err_q, timeout_err_d;

   logic            qual_sync, qual_frame, qual_line, burst_full;
   logic [2:0]      winner;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      burst_d       = burst_q;
      grant_d       = grant_q;
      ack_d         = 3'b000;
      next_seed_d   = 1'b0;
      next_bits_d   = 1'b0;
      timeout_err_d = timeout_err_q;
      winner        = 3'b000;
      qual_sync     = req_sync & ~block_reseed;
      qual_frame    = req_frame & ~block_reseed;
      qual_line     = req_line;
      burst_full    = (burst_q == BW'(SEED_BURST_MAX));

      case (state_q)
         S_IDLE: begin
            if (!req_line) begin
               burst_d = '0;
            end
            if (drbg_ready && (qual_sync || qual_frame || qual_line)) begin
               // The line scrambler is starved no longer than SEED_BURST_MAX seed commands.
               if (qual_line && burst_full) begin
                  winner = 3'b100;
               end else if (qual_sync) begin
                  winner = 3'b001;
               end else if (qual_frame) begin
                  winner = 3'b010;
               end else begin
                  winner = 3'b100;
               end
               grant_d = winner;
               state_d = S_ISSUE;
               if (winner[2]) begin
                  burst_d = '0;
               end else if (req_line && !burst_full) begin
                  burst_d = burst_q + BW'(1);
               end
            end
         end
         S_ISSUE: begin
            next_seed_d = ~grant_q[2];
            next_bits_d = grant_q[2];
            cnt_d       = CW'(1);
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            // Completion takes precedence over a timeout landing in the same cycle.
            if (drbg_done) begin
               ack_d   = grant_q;
               state_d = S_ACK;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               timeout_err_d = 1'b1;
               grant_d       = 3'b000;
               state_d       = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_ACK: begin
            grant_d = 3'b000;
            state_d = S_IDLE;
         end
         default: begin
            grant_d = 3'b000;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         burst_q       <= '0;
         grant_q       <= 3'b000;
         ack_q         <= 3'b000;
         next_seed_q   <= 1'b0;
         next_bits_q   <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         burst_q       <= burst_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         next_seed_q   <= next_seed_d;
         next_bits_q   <= next_bits_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign next_seed   = next_seed_q;
   assign next_bits   = next_bits_q;
   assign grant       = grant_q;
   assign ack         = ack_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
